// File: rtl/jpeg_stream_pkg.sv
// jpeg_stream_pkg: shared constants and FSM state type for the zigzag coefficient streamer.
package jpeg_stream_pkg;
  localparam int PIXEL_COUNT = 64;
  localparam int IDX_W = 6;
  localparam logic [1:0] COMP_Y = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;
  typedef enum logic [1:0] {IDLE, SEND_Y, SEND_CB, SEND_CR} state_e;
endpackage

// File: rtl/zz_next_nonzero.sv
// zz_next_nonzero: lowest nonzero index at or above start_i, plus zeros skipped to reach it.
// Only built with JPEG_STREAM_RLE_EN; the plain streamer has no zero scan.
`ifdef JPEG_STREAM_RLE_EN
module zz_next_nonzero
  import jpeg_stream_pkg::*;
(
  input  logic [PIXEL_COUNT-1:0] nz_i,
  input  logic [IDX_W-1:0]       start_i,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   found_o,
  output logic [IDX_W-1:0]       run_o
);
  always_comb begin
    idx_o = '0;
    found_o = 1'b0;
    for (int i = PIXEL_COUNT - 1; i >= 0; i--) begin
      if (nz_i[i] && i >= int'(start_i)) begin
        idx_o = IDX_W'(i);
        found_o = 1'b1;
      end
    end
    run_o = idx_o - start_i;
  end
endmodule
`endif

// File: rtl/jpeg_zigzag_coef_streamer.sv
// jpeg_zigzag_coef_streamer: captures a Y/Cb/Cr zigzag block and streams it as Y, Cb, Cr beats.
// JPEG_STREAM_RLE_EN compacts zero AC runs into (run, value) beats with an end-of-block beat.
module jpeg_zigzag_coef_streamer
  import jpeg_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 8,
  localparam int PIXELS = DATA_DEPTH * DATA_DEPTH
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         blk_valid,
  output logic                         blk_ready,
  input  logic [DATA_WIDTH*PIXELS-1:0] y_zigzag,
  input  logic [DATA_WIDTH*PIXELS-1:0] cb_zigzag,
  input  logic [DATA_WIDTH*PIXELS-1:0] cr_zigzag,
  output logic                         coef_valid,
  input  logic                         coef_ready,
  output logic [DATA_WIDTH-1:0]        coef_data,
  output logic [1:0]                   coef_comp,
  output logic [IDX_W-1:0]             coef_index,
  output logic [IDX_W-1:0]             coef_run,
  output logic                         coef_eob,
  output logic                         coef_last,
  output logic                         blk_last,
  output logic                         busy
);
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q [3][PIXELS];
  logic rdy_q;
  logic valid_q, valid_d, eob_q, eob_d, last_q, last_d, blast_q, blast_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0] comp_q, comp_d, comp_n;
  logic [IDX_W-1:0] idx_q, idx_d, idx_n, run_q, run_d;
  logic cap, xfer;
  assign cap = blk_valid && rdy_q;
  assign xfer = valid_q && coef_ready;
  assign idx_n = idx_q + IDX_W'(1);
  assign comp_n = (comp_q == COMP_CR) ? COMP_CR : comp_q + 2'd1;
`ifdef JPEG_STREAM_RLE_EN
  logic [PIXELS-1:0] nz;
  logic [IDX_W-1:0] nxt, nxt_run;
  logic found;
  always_comb begin
    nz = '0;
    for (int i = 0; i < PIXELS; i++) nz[i] = buf_q[comp_q][i] != '0;
  end
  zz_next_nonzero u_scan (
    .nz_i   (nz),
    .start_i(idx_n),
    .idx_o  (nxt),
    .found_o(found),
    .run_o  (nxt_run)
  );
`endif
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d = data_q;
    comp_d = comp_q;
    idx_d = idx_q;
    run_d = run_q;
    eob_d = eob_q;
    last_d = last_q;
    blast_d = blast_q;
    if (cap) begin
      state_d = SEND_Y;
      valid_d = 1'b1;
      data_d = y_zigzag[DATA_WIDTH-1:0];
      comp_d = COMP_Y;
      idx_d = '0;
      run_d = '0;
      eob_d = 1'b0;
      last_d = 1'b0;
      blast_d = 1'b0;
    end else if (xfer) begin
      if (blast_q) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end else if (last_q) begin
        state_d = (state_q == SEND_Y) ? SEND_CB : SEND_CR;
        comp_d = comp_n;
        idx_d = '0;
        data_d = buf_q[comp_n][0];
        run_d = '0;
        eob_d = 1'b0;
        last_d = 1'b0;
      end else begin
`ifdef JPEG_STREAM_RLE_EN
        // Trailing zeros collapse into one EOB beat parked at index 63.
        idx_d = found ? nxt : IDX_W'(PIXELS - 1);
        data_d = found ? buf_q[comp_q][nxt] : '0;
        run_d = found ? nxt_run : '0;
        eob_d = !found;
        last_d = !found || nxt == IDX_W'(PIXELS - 1);
`else
        idx_d = idx_n;
        data_d = buf_q[comp_q][idx_n];
        last_d = idx_n == IDX_W'(PIXELS - 1);
`endif
        blast_d = last_d && comp_q == COMP_CR;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int i = 0; i < PIXELS; i++) begin
        buf_q[0][i] <= y_zigzag[i*DATA_WIDTH +: DATA_WIDTH];
        buf_q[1][i] <= cb_zigzag[i*DATA_WIDTH +: DATA_WIDTH];
        buf_q[2][i] <= cr_zigzag[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdy_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
      comp_q <= COMP_Y;
      idx_q <= '0;
      run_q <= '0;
      eob_q <= 1'b0;
      last_q <= 1'b0;
      blast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q <= state_d == IDLE;
      valid_q <= valid_d;
      data_q <= data_d;
      comp_q <= comp_d;
      idx_q <= idx_d;
      run_q <= run_d;
      eob_q <= eob_d;
      last_q <= last_d;
      blast_q <= blast_d;
    end
  end
  assign blk_ready = rdy_q;
  assign busy = state_q != IDLE;
  assign coef_valid = valid_q;
  assign coef_data = data_q;
  assign coef_comp = comp_q;
  assign coef_index = idx_q;
  assign coef_run = run_q;
  assign coef_eob = eob_q;
  assign coef_last = last_q;
  assign blk_last = blast_q;
endmodule

// File: tb/tb_jpeg_zigzag_coef_streamer.sv
// tb_jpeg_zigzag_coef_streamer: table-driven and random block streaming checked against a beat-list model.
module tb_jpeg_zigzag_coef_streamer;
  localparam int DW = 32;
  localparam int N = 64;
`ifdef JPEG_STREAM_RLE_EN
  localparam bit RLE = 1'b1;
`else
  localparam bit RLE = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, blk_valid, blk_ready, coef_valid, coef_ready, coef_eob, coef_last, blk_last, busy;
  logic [DW*N-1:0] y_zigzag, cb_zigzag, cr_zigzag;
  logic [DW-1:0] coef_data;
  logic [1:0] coef_comp;
  logic [5:0] coef_index, coef_run;
  always #5 clk = ~clk;
  jpeg_zigzag_coef_streamer dut (
    .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .y_zigzag(y_zigzag), .cb_zigzag(cb_zigzag), .cr_zigzag(cr_zigzag),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_comp(coef_comp), .coef_index(coef_index), .coef_run(coef_run),
    .coef_eob(coef_eob), .coef_last(coef_last), .blk_last(blk_last), .busy(busy)
  );
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  comp;
    logic [5:0]  idx;
    logic [5:0]  run;
    logic        eob;
    logic        last;
    logic        blast;
  } beat_t;
  typedef struct {
    int pat;
    int prob;
    int cnt;
  } vec_t;
  logic [DW-1:0] blk [3][N];
  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic beat_t cur_beat();
    return {coef_data, coef_comp, coef_index, coef_run, coef_eob, coef_last, blk_last};
  endfunction
  task automatic fill(input int pat);
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < N; i++)
        case (pat)
          0: blk[c][i] = 32'(c * 256 + i);
          1: blk[c][i] = 32'hFFFF_FFFF;
          2: blk[c][i] = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
          default: blk[c][i] = (c == 2) ? 32'(768 + i) : 32'd0;
        endcase
    if (pat == 3) begin
      blk[0][0] = 32'd5;
      blk[0][3] = 32'hFFFF_FFFE;
      blk[0][10] = 32'd7;
    end
  endtask
  task automatic build();
    beat_t b;
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      int zr = 0;
      for (int i = 0; i < N; i++) begin
        if (!RLE || i == 0 || blk[c][i] != 0) begin
          exp_q.push_back('{blk[c][i], 2'(c), 6'(i), 6'(zr), 1'b0, i == N - 1, 1'b0});
          zr = 0;
        end else zr++;
      end
      if (RLE && blk[c][N-1] == 0) exp_q.push_back('{32'd0, 2'(c), 6'd63, 6'd0, 1'b1, 1'b1, 1'b0});
    end
    b = exp_q.pop_back();
    b.blast = 1'b1;
    exp_q.push_back(b);
  endtask
  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      y_zigzag[i*DW +: DW] = blk[0][i];
      cb_zigzag[i*DW +: DW] = blk[1][i];
      cr_zigzag[i*DW +: DW] = blk[2][i];
    end
  endtask
  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      y_zigzag[i*DW +: DW] = $urandom;
      cb_zigzag[i*DW +: DW] = 32'hFFFF_FFFF;
      cr_zigzag[i*DW +: DW] = $urandom;
    end
    blk_valid = 1'($urandom_range(0, 1));
  endtask
  task automatic capture();
    int t = 0;
    drive_bus();
    blk_valid = 1'b1;
    coef_ready = 1'b0;
    while (!blk_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("capture_wait", 64'(t < 50), 64'd1);
    @(negedge clk);
    chk("first_beat_valid", 64'(coef_valid), 64'd1);
    chk("busy_streaming", 64'(busy), 64'd1);
    chk("ready_low_streaming", 64'(blk_ready), 64'd0);
  endtask
  task automatic run_block(input int pat, input int prob, input int cnt);
    int n = 0;
    int cyc = 0;
    bit stall = 1'b0;
    beat_t held, cur, exp;
    fill(pat);
    build();
    capture();
    while (exp_q.size() != 0 && cyc < 3000) begin
      cur = cur_beat();
      scramble();
      if (stall) begin
        chk("stall_valid", 64'(coef_valid), 64'd1);
        chk("stall_hold", 64'(cur), 64'(held));
      end
      coef_ready = $urandom_range(1, 100) <= prob;
      stall = 1'b0;
      if (coef_valid && coef_ready) begin
        exp = exp_q.pop_front();
        chk($sformatf("beat%0d", n), 64'(cur), 64'(exp));
        n++;
      end else if (coef_valid) begin
        stall = 1'b1;
        held = cur;
      end
      @(negedge clk);
      cyc++;
    end
    blk_valid = 1'b0;
    coef_ready = 1'b0;
    chk("stream_complete", 64'(exp_q.size()), 64'd0);
    chk("end_valid_low", 64'(coef_valid), 64'd0);
    chk("end_blk_ready", 64'(blk_ready), 64'd1);
    chk("end_busy_low", 64'(busy), 64'd0);
    if (cnt >= 0) chk("beat_count", 64'(n), 64'(cnt));
    if (prob == 100) chk("full_rate_cycles", 64'(cyc), 64'(n));
  endtask
  vec_t tbl[5];
  initial begin
    int n;
    tbl[0] = '{0, 100, 192};
    tbl[1] = '{0, 50, 192};
    tbl[2] = '{1, 100, 192};
    tbl[3] = '{2, 60, -1};
    tbl[4] = '{3, 70, RLE ? 70 : 192};
    reset = 1'b1;
    blk_valid = 1'b0;
    coef_ready = 1'b0;
    y_zigzag = '0;
    cb_zigzag = '0;
    cr_zigzag = '0;
    #1;
    chk("rst_valid", 64'(coef_valid), 64'd0);
    chk("rst_beat", 64'(cur_beat()), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    chk("rst_blk_ready", 64'(blk_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_blk_ready", 64'(blk_ready), 64'd1);
    for (int k = 0; k < 5; k++) run_block(tbl[k].pat, tbl[k].prob, tbl[k].cnt);
    for (int k = 0; k < 3; k++) run_block(2, 40 + 30 * k, -1);
    fill(0);
    capture();
    blk_valid = 1'b0;
    coef_ready = 1'b1;
    n = 0;
    for (int t = 0; t < 200 && n < 70; t++) begin
      if (coef_valid) n++;
      @(negedge clk);
    end
    chk("beats_before_reset", 64'(n), 64'd70);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(coef_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_index", 64'(coef_index), 64'd0);
    chk("mid_rst_blk_ready", 64'(blk_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    coef_ready = 1'b0;
    @(negedge clk);
    chk("rel_blk_ready", 64'(blk_ready), 64'd1);
    chk("rel_busy", 64'(busy), 64'd0);
    chk("rel_valid", 64'(coef_valid), 64'd0);
    run_block(0, 100, 192);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jpeg_zigzag_coef_streamer.md
Name: jpeg_zigzag_coef_streamer

Overview:
- Consumer end of the compression pipeline. Captures one 8x8 block of zigzag-ordered Y/Cb/Cr coefficients, presented as three flat parallel buses, in a single handshake.
- Serialises the block as a valid/ready coefficient stream in the order Y[0..63], Cb[0..63], Cr[0..63].
- Feeds the entropy coder and the output writer.
- Optionally compacts zero AC runs into (run, value) beats with end-of-block.

Parameters:
- DATA_WIDTH, 32, width of one signed two's-complement coefficient.
- DATA_DEPTH, 8, block edge. PIXEL_COUNT = DATA_DEPTH*DATA_DEPTH (64) is a derived localparam.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- blk_valid  in  1  upstream block is present on the *_zigzag buses.
- blk_ready  out  1  streamer can capture a block (high only in IDLE).
- y_zigzag  in  DATA_WIDTH*PIXEL_COUNT  Y coefficients; index i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- cb_zigzag  in  DATA_WIDTH*PIXEL_COUNT  Cb coefficients, same packing.
- cr_zigzag  in  DATA_WIDTH*PIXEL_COUNT  Cr coefficients, same packing.
- coef_valid  out  1  output beat valid.
- coef_ready  in  1  downstream accepts the beat.
- coef_data  out  DATA_WIDTH  coefficient value.
- coef_comp  out  2  component: 0=Y, 1=Cb, 2=Cr.
- coef_index  out  6  zigzag index 0..63.
- coef_run  out  6  zeros skipped before this beat (0 without RLE_EN).
- coef_eob  out  1  end-of-block beat (0 without RLE_EN).
- coef_last  out  1  last beat of the current component.
- blk_last  out  1  last beat of the whole block (Cr last).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; coef_valid=0; coef_data=0; coef_comp=0; coef_index=0; coef_run=0; coef_eob=0; coef_last=0; blk_last=0; busy=0.
  - blk_ready=1 from the first clk edge after reset deasserts.
  - Buffer contents are don't-care.
- FSM states: IDLE, SEND_Y, SEND_CB, SEND_CR.
- Capture:
  - In IDLE, blk_valid && blk_ready registers all 3*64 words into an internal buffer. State goes to SEND_Y on the same edge.
  - Input buses are ignored at all other times. Changes after capture do not affect output.
- Output timing:
  - The first beat (Y[0]) is valid in the cycle after capture. Capture-to-first-beat latency is 1 cycle.
  - All coef_* outputs are registered.
- Handshake:
  - A beat transfers on coef_valid && coef_ready.
  - While coef_valid=1 and coef_ready=0, all coef_* outputs hold stable.
  - coef_valid never drops without a transfer.
  - With coef_ready held high, one beat is issued per cycle.
- Advancing:
  - The index counter increments per transfer.
  - Index 63 transferred in SEND_Y moves to SEND_CB; in SEND_CB moves to SEND_CR; in SEND_CR moves to IDLE.
- Flags:
  - coef_last=1 on the final beat of each component.
  - blk_last=1 only on the final Cr beat.
- End of block:
  - After the blk_last transfer, coef_valid=0 and blk_ready=1 in the next cycle. There is no capture overlap.
  - Minimum period is 193 cycles per block without RLE_EN.
- blk_valid while busy: ignored, no error; the block must be held by upstream.
- Reset mid-stream: the stream aborts; the partial block is discarded and not resumed.

Optional Feature:
- Macro: JPEG_STREAM_RLE_EN.
- With JPEG_STREAM_RLE_EN:
  - Per component, index 0 (DC) is always emitted.
  - AC coefficients equal to 0 are skipped.
  - Each emitted AC beat carries coef_run = count of zeros skipped since the previous emitted beat.
  - If all coefficients after the last nonzero through index 63 are zero, a single EOB beat is emitted: coef_eob=1, coef_data=0, coef_run=0, coef_index=63, coef_last=1.
  - If index 63 is nonzero it is emitted normally, with no EOB.
  - Selecting the next nonzero index costs no bubble: the next beat is available on the cycle after a transfer.
- Without the macro:
  - Every coefficient is emitted.
  - coef_run and coef_eob are tied 0.
  - The zero-scan logic is absent.

Decomposition:
- Package jpeg_stream_pkg holds:
  - COMP_Y=0, COMP_CB=1, COMP_CR=2;
  - the state enum;
  - PIXEL_COUNT and index width constants.
- Sub-module zz_next_nonzero (RLE only): masked 64-bit nonzero bitmap plus start index in; next nonzero index, found flag, and run length out; combinational priority encoder.

Test Plan:
- Ramp block (Y[i]=i, Cb[i]=0x100+i, Cr[i]=0x200+i), coef_ready=1 -> 192 beats in order with correct comp/index; coef_last at beats 63/127/191; blk_last only at beat 191; blk_ready=1 one cycle after.
- Same block, coef_ready random 50% -> identical beat sequence; outputs stable during every stall cycle.
- Change blk_valid and the input data after capture and during streaming -> output unchanged. Second block (Y[i]=0xFFFFFFFF) is captured only after return to IDLE.
- Reset asserted at beat 70 -> coef_valid=0 immediately. After release: blk_ready=1, busy=0; a new block streams from Y[0].
- RLE_EN, Y = {[0]=5, [3]=-2, [10]=7, else 0} -> beats (0,5,run0), (3,0xFFFFFFFE,run2), (10,7,run6), EOB(63,run0,last).
- RLE_EN, Cb all zero -> beats (0,0) then EOB. Cr all nonzero -> 64 beats, no EOB, last at index 63.
